// File: rtl/tm1638_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_scan_ctrl
// Purpose  : Frame sequencer for a TM1638 LED/key driver. It sits in front of
//            the tm1638 byte serializer. Each refresh period it sends the
//            write-mode command, the 16-byte display RAM image (8 digit
//            segment bytes interleaved with 8 discrete LEDs) and the display
//            control byte. It then optionally reads back the 4 key-scan bytes.
//            It owns STB and the DIO direction enable. Every byte goes through
//            the serializer's latch/busy handshake.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            en                - frame enable, sampled only when a frame is due
//            seg_data, led     - display content, snapshotted at frame start
//            brightness,
//            display_on        - display control, snapshotted at frame start
//            eng_latch, eng_rw,
//            eng_data, eng_busy- serializer handshake (eng_data is tri-state)
//            stb, dio_oe       - TM1638 strobe (active low), DIO drive enable
//            keys, keys_valid  - key-scan bytes {k3,k2,k1,k0}, update pulse
//            frame_busy        - high while a frame is in progress
// Options  : TM1638_KEYSCAN_EN - when defined, the key readback command (0x42
//            plus 4 read bytes) ends each frame. When undefined, keys stays 0,
//            keys_valid stays low and dio_oe stays 1.
// Revision : 1.0 - initial release
// ============================================================================
module tm1638_scan_ctrl #(
    parameter int REFRESH_DIV = 120000,
    parameter int STB_GAP     = 4,
    parameter int READ_WAIT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] seg_data,
    input  logic [7:0]  led,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    output logic        eng_latch,
    output logic        eng_rw,
    inout  wire  [7:0]  eng_data,
    input  logic        eng_busy,
    output logic        stb,
    output logic        dio_oe,
    output logic [31:0] keys,
    output logic        keys_valid,
    output logic        frame_busy
);

    localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [15:0] c_gap_last = 16'(STB_GAP - 1);
    localparam logic [15:0] c_rdw_last = 16'(READ_WAIT - 1);

`ifdef TM1638_KEYSCAN_EN
    localparam logic [1:0] c_last_cmd = 2'd3;
`else
    localparam logic [1:0] c_last_cmd = 2'd2;
`endif

    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_stb_lo    = 4'd1;
    localparam logic [3:0] c_st_send      = 4'd2;
    localparam logic [3:0] c_st_wait_busy = 4'd3;
    localparam logic [3:0] c_st_stb_hi    = 4'd4;
    localparam logic [3:0] c_st_gap       = 4'd5;
    localparam logic [3:0] c_st_rd_wait   = 4'd6;
    localparam logic [3:0] c_st_recv      = 4'd7;
    localparam logic [3:0] c_st_done      = 4'd8;

    logic [3:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_due_pend;
    logic [63:0]        r_seg_snap;
    logic [7:0]         r_led_snap;
    logic [2:0]         r_bright;
    logic               r_disp;
    logic [1:0]         r_cmd;
    logic [4:0]         r_idx;
    logic [1:0]         r_skip;
    logic [15:0]        r_wait;
    logic               r_latch;
    logic               r_rw;
    logic [7:0]         r_tx;
    logic               r_stb;
    logic               r_frame_busy;
`ifdef TM1638_KEYSCAN_EN
    logic               r_dio_oe;
    logic [31:0]        r_keys;
    logic [31:0]        r_keys_acc;
    logic               r_keys_valid;
`endif

    logic [2:0]         w_grid;
    logic [7:0]         w_tx_byte;
    logic [4:0]         w_last_idx;

    // Byte k (k>=1) of C2 goes to RAM address k-1: odd k carries segments of
    // grid k>>1, even k carries the LED of grid (k>>1)-1. For k=16 the 3-bit
    // subtraction wraps to grid 7.
    always_comb begin
        w_grid     = r_idx[0] ? r_idx[3:1] : (r_idx[3:1] - 3'd1);
        w_last_idx = (r_cmd == 2'd1) ? 5'd16 : 5'd0;
        w_tx_byte  = 8'h40;
        case (r_cmd)
            2'd0: w_tx_byte = 8'h40;
            2'd1: begin
                if (r_idx == 5'd0)
                    w_tx_byte = 8'hC0;
                else if (r_idx[0])
                    w_tx_byte = r_seg_snap[{w_grid, 3'b000} +: 8];
                else
                    w_tx_byte = {7'b0, r_led_snap[w_grid]};
            end
            2'd2: w_tx_byte = {4'b1000, r_disp, r_bright};
            default: w_tx_byte = 8'h42;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_due_pend   <= 1'b0;
            r_seg_snap   <= '0;
            r_led_snap   <= '0;
            r_bright     <= '0;
            r_disp       <= 1'b0;
            r_cmd        <= '0;
            r_idx        <= '0;
            r_skip       <= '0;
            r_wait       <= '0;
            r_latch      <= 1'b0;
            r_rw         <= 1'b1;
            r_tx         <= '0;
            r_stb        <= 1'b1;
            r_frame_busy <= 1'b0;
`ifdef TM1638_KEYSCAN_EN
            r_dio_oe     <= 1'b1;
            r_keys       <= '0;
            r_keys_acc   <= '0;
            r_keys_valid <= 1'b0;
`endif
        end else begin
            r_latch <= 1'b0;
`ifdef TM1638_KEYSCAN_EN
            r_keys_valid <= 1'b0;
`endif
            r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            // A frame falling due while one is still running is remembered,
            // so an overlong frame is followed directly by the next one.
            if (r_cnt == '0 && r_state != c_st_idle)
                r_due_pend <= 1'b1;

            case (r_state)
                c_st_idle: begin
                    if (r_cnt == '0 || r_due_pend) begin
                        r_due_pend <= 1'b0;
                        if (en) begin
                            r_seg_snap   <= seg_data;
                            r_led_snap   <= led;
                            r_bright     <= brightness;
                            r_disp       <= display_on;
                            r_frame_busy <= 1'b1;
                            r_cmd        <= 2'd0;
                            r_idx        <= 5'd0;
                            r_state      <= c_st_stb_lo;
                        end
                    end
                end
                c_st_stb_lo: begin
                    r_stb   <= 1'b0;
                    r_state <= c_st_send;
                end
                c_st_send: begin
                    if (!eng_busy) begin
                        r_latch <= 1'b1;
                        r_rw    <= 1'b1;
                        r_tx    <= w_tx_byte;
                        r_skip  <= 2'd2;
                        r_state <= c_st_wait_busy;
                    end
                end
                c_st_wait_busy: begin
                    // The serializer's busy is registered, so it is not
                    // trusted on the latch cycle or the cycle after it.
                    if (r_skip != 2'd0) begin
                        r_skip <= r_skip - 2'd1;
                    end else if (!eng_busy) begin
`ifdef TM1638_KEYSCAN_EN
                        if (!r_rw) begin
                            // Shift in from the top so k0 ends up in [7:0].
                            r_keys_acc <= {eng_data, r_keys_acc[31:8]};
                            if (r_idx == 5'd4) begin
                                r_state <= c_st_stb_hi;
                            end else begin
                                r_idx   <= r_idx + 5'd1;
                                r_state <= c_st_recv;
                            end
                        end else if (r_cmd == 2'd3) begin
                            r_idx   <= 5'd1;
                            r_wait  <= '0;
                            r_state <= c_st_rd_wait;
                        end else
`endif
                        if (r_idx == w_last_idx) begin
                            r_state <= c_st_stb_hi;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= c_st_send;
                        end
                    end
                end
                c_st_rd_wait: begin
                    r_wait <= r_wait + 16'd1;
                    if (r_wait == c_rdw_last)
                        r_state <= c_st_recv;
                end
                c_st_recv: begin
                    if (!eng_busy) begin
                        r_latch  <= 1'b1;
                        r_rw     <= 1'b0;
`ifdef TM1638_KEYSCAN_EN
                        r_dio_oe <= 1'b0;
`endif
                        r_skip   <= 2'd2;
                        r_state  <= c_st_wait_busy;
                    end
                end
                c_st_stb_hi: begin
                    r_stb   <= 1'b1;
                    r_rw    <= 1'b1;
                    r_wait  <= '0;
`ifdef TM1638_KEYSCAN_EN
                    if (r_cmd == 2'd3) begin
                        r_keys       <= r_keys_acc;
                        r_keys_valid <= 1'b1;
                        r_dio_oe     <= 1'b1;
                    end
`endif
                    r_state <= c_st_gap;
                end
                c_st_gap: begin
                    if (r_wait == c_gap_last) begin
                        if (r_cmd == c_last_cmd) begin
                            r_state <= c_st_done;
                        end else begin
                            r_cmd   <= r_cmd + 2'd1;
                            r_idx   <= 5'd0;
                            r_state <= c_st_stb_lo;
                        end
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                c_st_done: begin
                    r_frame_busy <= 1'b0;
                    r_state      <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign eng_latch  = r_latch;
    assign eng_rw     = r_rw;
    assign eng_data   = r_rw ? r_tx : 8'hzz;
    assign stb        = r_stb;
    assign frame_busy = r_frame_busy;
`ifdef TM1638_KEYSCAN_EN
    assign dio_oe     = r_dio_oe;
    assign keys       = r_keys;
    assign keys_valid = r_keys_valid;
`else
    assign dio_oe     = 1'b1;
    assign keys       = 32'h0;
    assign keys_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tm1638_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1638_scan_ctrl
// Purpose  : Self-checking bench for tm1638_scan_ctrl. A serializer model
//            answers the latch/busy handshake, and a scoreboard holds the
//            expected byte stream and key words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm1638_scan_ctrl;

    localparam int REFRESH_DIV = 600;
    localparam int STB_GAP     = 4;
    localparam int READ_WAIT   = 16;
`ifdef TM1638_KEYSCAN_EN
    localparam int c_ncmd = 4;
    localparam int c_nkv  = 1;
    localparam int c_nbyt = 24;
`else
    localparam int c_ncmd = 3;
    localparam int c_nkv  = 0;
    localparam int c_nbyt = 19;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] seg;
    logic [7:0]  led;
    logic [2:0]  br;
    logic        on;
    logic        busy = 1'b0;
    wire  [7:0]  eng_data;
    logic        eng_latch, eng_rw, stb, dio_oe, keys_valid, frame_busy;
    logic [31:0] keys;
    logic [7:0]  rd_byte = 8'h00;

    always #5 clk = ~clk;

    assign eng_data = eng_rw ? 8'hzz : rd_byte;

    tm1638_scan_ctrl #(
        .REFRESH_DIV(REFRESH_DIV),
        .STB_GAP    (STB_GAP),
        .READ_WAIT  (READ_WAIT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seg_data  (seg),
        .led       (led),
        .brightness(br),
        .display_on(on),
        .eng_latch (eng_latch),
        .eng_rw    (eng_rw),
        .eng_data  (eng_data),
        .eng_busy  (busy),
        .stb       (stb),
        .dio_oe    (dio_oe),
        .keys      (keys),
        .keys_valid(keys_valid),
        .frame_busy(frame_busy)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [8:0]  sq[$];   // {rw, data}; read bytes expect 9'h000
    logic [31:0] kq[$];

    int busy_len   = 3;
    bit early_mode = 1'b0;
    int lat_total  = 0;
    int lat_frame  = 0;
    int stb_falls  = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [63:0] s, input logic [7:0] l,
                              input logic [2:0] b, input logic o);
        sq.push_back(9'h140);
        sq.push_back(9'h1C0);
        for (int i = 0; i < 8; i++) begin
            sq.push_back({1'b1, s[8*i +: 8]});
            sq.push_back({1'b1, 7'b0, l[i]});
        end
        sq.push_back({1'b1, 4'b1000, o, b});
`ifdef TM1638_KEYSCAN_EN
        sq.push_back(9'h142);
        for (int i = 0; i < 4; i++) sq.push_back(9'h000);
        kq.push_back(32'h88442211);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_start();
        for (int t = 0; t < 700 && !frame_busy; t++) tick();
        check_val("start_timeout", frame_busy, 1);
    endtask

    task automatic wait_end();
        for (int t = 0; t < 3000 && frame_busy; t++) tick();
        check_val("end_timeout", frame_busy, 0);
    endtask

    task automatic wait_lat(input int n);
        for (int t = 0; t < 2000 && lat_frame < n; t++) tick();
        check_val("lat_timeout", lat_frame >= n, 1);
    endtask

    task automatic drain();
        check_val("sb_drain", sq.size(), 0);
        check_val("kq_drain", kq.size(), 0);
    endtask

    // Serializer model and output monitor, evaluated away from the active edge.
    initial begin : g_model
        logic [7:0] rd_vals [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
        int   busy_cnt = 0, early_cnt = 0, early_phase = 0, rd_i = 0;
        int   cyc = 0, hi_run = 100, win_cnt = 0, kv_cnt = 0;
        logic prev_stb = 1'b1, prev_fb = 1'b0, prev_oe = 1'b1;
        logic [8:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; win_cnt = 0; kv_cnt = 0; lat_frame = 0; hi_run = 100;
            end else begin
                cyc++;
            end

            if (eng_latch) begin
                check_val("latch_while_busy", busy, 0);
                lat_total++;
                lat_frame++;
                check_val("sb_nonempty", sq.size() > 0, 1);
                if (sq.size() > 0) begin
                    exp_b = sq.pop_front();
                    check_val("byte", {eng_rw, eng_rw ? eng_data : 8'h00}, exp_b);
                end
                if (!eng_rw) begin
                    rd_byte = rd_vals[rd_i];
                    rd_i    = (rd_i + 1) % 4;
                end
                busy = 1'b1; busy_cnt = busy_len; early_phase = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    busy = 1'b0;
                    if (early_mode) early_phase = 1;
                end
            end else if (early_phase == 1) begin
                busy = 1'b1; early_cnt = 6; early_phase = 2;
            end else if (early_phase == 2) begin
                early_cnt--;
                if (early_cnt == 0) begin busy = 1'b0; early_phase = 0; end
            end

            if (prev_stb && !stb) begin
                check_val("stb_gap", hi_run >= STB_GAP, 1);
                win_cnt++;
                stb_falls++;
            end
            if (stb) hi_run++; else hi_run = 0;

            if (keys_valid) begin
                kv_cnt++;
                check_val("kv_on_stb_rise", {prev_stb, stb}, 2'b01);
                check_val("kq_nonempty", kq.size() > 0, 1);
                if (kq.size() > 0) check_val("keys", keys, kq.pop_front());
            end
            if (!prev_oe && dio_oe) check_val("oe_rise_with_kv", keys_valid, 1);
            if (prev_oe && !dio_oe) check_val("oe_fall_on_read", {eng_latch, eng_rw}, 2'b10);

            if (!prev_fb && frame_busy && !rst) begin
                check_val("frame_phase", cyc % REFRESH_DIV, 2);
                lat_frame = 0; win_cnt = 0; kv_cnt = 0;
            end
            if (prev_fb && !frame_busy && !rst) begin
                check_val("stb_windows", win_cnt, c_ncmd);
                check_val("kv_pulses", kv_cnt, c_nkv);
            end
            prev_stb = stb; prev_fb = frame_busy; prev_oe = dio_oe;
        end
    end

    initial begin : g_stim
        int before_lat, before_fall;
        rst = 1'b1; en = 1'b1;
        seg = 64'h0706050403020100; led = 8'hA5; br = 3'd7; on = 1'b1;
        push_frame(seg, led, br, on);
        repeat (3) tick();
        check_val("rst_stb", stb, 1);
        check_val("rst_latch", eng_latch, 0);
        check_val("rst_rw", eng_rw, 1);
        check_val("rst_oe", dio_oe, 1);
        check_val("rst_keys", keys, 0);
        check_val("rst_kv", keys_valid, 0);
        check_val("rst_fbusy", frame_busy, 0);

        // First frame right after reset release.
        rst = 1'b0;
        wait_start();
        en = 1'b0;
        wait_end();
        drain();

        // Disabled for more than a frame period: nothing happens.
        before_lat  = lat_total;
        before_fall = stb_falls;
        repeat (REFRESH_DIV + 100) tick();
        check_val("skip_no_latch", lat_total - before_lat, 0);
        check_val("skip_stb_high", stb_falls - before_fall, 0);
        check_val("skip_fbusy", frame_busy, 0);

        // Re-enable: next frame aligned to counter 0.
        push_frame(seg, led, br, on);
        en = 1'b1;
        wait_start();
        en = 1'b0;
        wait_end();
        drain();

        // Inputs change mid-C2: current frame keeps its snapshot.
        push_frame(seg, led, br, on);
        en = 1'b1;
        wait_start();
        en = 1'b0;
        wait_lat(6);
        seg = 64'hF0E1D2C3B4A59687; led = 8'h3C; br = 3'd2; on = 1'b0;
        push_frame(seg, led, br, on);
        wait_end();
        check_val("snap_pending", sq.size(), c_nbyt);
        en = 1'b1;
        wait_start();
        en = 1'b0;
        wait_end();
        drain();

        // Reset in the middle of C2.
        push_frame(seg, led, br, on);
        en = 1'b1;
        wait_start();
        en = 1'b0;
        wait_lat(8);
        rst = 1'b1;
        tick();
        check_val("mid_rst_stb", stb, 1);
        check_val("mid_rst_latch", eng_latch, 0);
        check_val("mid_rst_fbusy", frame_busy, 0);
        check_val("mid_rst_oe", dio_oe, 1);
        sq.delete();
        kq.delete();
        tick();
        push_frame(seg, led, br, on);
        en  = 1'b1;
        rst = 1'b0;
        wait_start();
        en = 1'b0;
        wait_end();
        drain();

        // Busy reasserted before the next byte is due.
        early_mode = 1'b1;
        push_frame(seg, led, br, on);
        en = 1'b1;
        wait_start();
        en = 1'b0;
        wait_end();
        drain();
        early_mode = 1'b0;

        // Long busy per byte.
        busy_len = 40;
        seg = 64'h1122334455667788; led = 8'h81; br = 3'd5; on = 1'b1;
        push_frame(seg, led, br, on);
        en = 1'b1;
        wait_start();
        en = 1'b0;
        wait_end();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
